// File: rtl/tone_voice_bank.sv
// Multi-voice square-wave tone generator with a shared runtime-programmable millisecond prescaler.
// Define TONE_PWM_MIX_EN to sum the voices by PWM instead of ORing them onto the speaker pin.
module tone_voice_bank #(
  parameter int N_VOICES = 4,
  parameter int TICK_W   = 16,
  parameter int PERIOD_W = 12,
  parameter int DUR_W    = 12,
  localparam int VSEL_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TICK_W-1:0]   ticks_per_milli,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [VSEL_W-1:0]   note_voice,
  input  logic [PERIOD_W-1:0] note_half_period,
  input  logic [DUR_W-1:0]    note_dur_ms,
  output logic [N_VOICES-1:0] voice_active,
  output logic                sound,
  output logic [7:0]          led
);

  typedef enum logic {V_IDLE, V_PLAYING} voice_state_e;

  voice_state_e        state    [N_VOICES];
  logic [PERIOD_W-1:0] half_per [N_VOICES];
  logic [PERIOD_W-1:0] phase    [N_VOICES];
  logic [DUR_W-1:0]    dur_left [N_VOICES];
  logic [N_VOICES-1:0] wave;

  logic [TICK_W-1:0] pre_cnt;
  logic              ms_tick;
  logic              accept;

  // A lowered ticks_per_milli below the current count also counts as a wrap.
  assign ms_tick = (ticks_per_milli != '0) && (pre_cnt >= ticks_per_milli - TICK_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  pre_cnt <= '0;
    else if (ms_tick || ticks_per_milli == '0)   pre_cnt <= '0;
    else                                         pre_cnt <= pre_cnt + TICK_W'(1);
  end

  // Out-of-range voice indices match no voice, so they stay ready and are dropped.
  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned and infers a latch.
    note_ready = 1'b1;
    for (int i = 0; i < N_VOICES; i++) begin
      if (note_voice == VSEL_W'(i)) note_ready = (state[i] == V_IDLE);
    end
  end

  assign accept = note_valid & note_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these per-voice arrays are plain registers, not RAM, so resetting them is fine.
      for (int i = 0; i < N_VOICES; i++) begin
        state[i]    <= V_IDLE;
        half_per[i] <= '0;
        phase[i]    <= '0;
        dur_left[i] <= '0;
        wave[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_VOICES; i++) begin
        case (state[i])
          V_IDLE: begin
            if (accept && note_voice == VSEL_W'(i) && note_dur_ms != '0) begin
              state[i]    <= V_PLAYING;
              half_per[i] <= note_half_period;
              dur_left[i] <= note_dur_ms;
              phase[i]    <= '0;
              wave[i]     <= 1'b0;
            end
          end
          V_PLAYING: begin
            if (ms_tick && dur_left[i] == DUR_W'(1)) begin
              state[i] <= V_IDLE;
              wave[i]  <= 1'b0;
              phase[i] <= '0;
            end else begin
              if (ms_tick) dur_left[i] <= dur_left[i] - DUR_W'(1);
              if (half_per[i] == '0) begin
                wave[i]  <= 1'b0;
                phase[i] <= '0;
              end else if (phase[i] >= half_per[i] - PERIOD_W'(1)) begin
                phase[i] <= '0;
                wave[i]  <= ~wave[i];
              end else begin
                phase[i] <= phase[i] + PERIOD_W'(1);
              end
            end
          end
          default: state[i] <= V_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_VOICES; i++) voice_active[i] = (state[i] == V_PLAYING);
  end

`ifdef TONE_PWM_MIX_EN
  logic [VSEL_W-1:0] pwm_cnt;
  logic [3:0]        wave_sum;

  always_comb begin
    wave_sum = '0;
    for (int i = 0; i < N_VOICES; i++) wave_sum = wave_sum + 4'(wave[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      sound   <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == VSEL_W'(N_VOICES - 1)) ? '0 : pwm_cnt + VSEL_W'(1);
      sound   <= (4'(pwm_cnt) < wave_sum);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sound <= 1'b0;
    else        sound <= |wave;
  end
`endif

  always_comb begin
    led                 = '0;
    led[N_VOICES-1:0]   = voice_active;
    led[7]              = sound;
  end

endmodule

// File: tb/tb_tone_voice_bank.sv
// Scoreboard bench for tone_voice_bank: a per-cycle reference model pushes expected outputs,
// a monitor pops and compares them one step after every rising edge.
module tb_tone_voice_bank;

  localparam int N      = 5;
  localparam int VSEL_W = (N > 1) ? $clog2(N) : 1;

  logic              clk;
  logic              rst_n;
  logic [15:0]       ticks_per_milli;
  logic              note_valid;
  logic              note_ready;
  logic [VSEL_W-1:0] note_voice;
  logic [11:0]       note_half_period;
  logic [11:0]       note_dur_ms;
  logic [N-1:0]      voice_active;
  logic              sound;
  logic [7:0]        led;

  tone_voice_bank #(.N_VOICES(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ticks_per_milli  (ticks_per_milli),
    .note_valid       (note_valid),
    .note_ready       (note_ready),
    .note_voice       (note_voice),
    .note_half_period (note_half_period),
    .note_dur_ms      (note_dur_ms),
    .voice_active     (voice_active),
    .sound            (sound),
    .led              (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [N-1:0] active;
    bit         snd;
    bit         ready;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: each voice tracks ms remaining and cycles since it started.
  bit m_play[N];
  int m_rem[N];
  int m_hp[N];
  int m_age[N];
  int m_cnt;
  int m_pwm;

  function automatic bit wave_of(input int i);
    if (!m_play[i] || m_hp[i] == 0) return 1'b0;
    return ((m_age[i] / m_hp[i]) % 2) == 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_play[i] = 0; m_rem[i] = 0; m_hp[i] = 0; m_age[i] = 0;
    end
    m_cnt = 0;
    m_pwm = 0;
    sb.delete();
  endtask

  task automatic model_step();
    int   tpm_i;
    int   sum;
    int   v;
    bit   tick;
    bit   snd;
    bit   acc;
    exp_t e;
    tpm_i = int'(ticks_per_milli);
    tick  = (tpm_i != 0) && (m_cnt >= tpm_i - 1);
    m_cnt = (tick || tpm_i == 0) ? 0 : m_cnt + 1;
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(wave_of(i));
`ifdef TONE_PWM_MIX_EN
    snd   = (m_pwm < sum);
    m_pwm = (m_pwm + 1) % N;
`else
    snd = (sum != 0);
`endif
    v   = int'(note_voice);
    acc = note_valid && (v >= N || !m_play[v]);
    for (int i = 0; i < N; i++) begin
      if (m_play[i]) begin
        if (tick && m_rem[i] == 1) m_play[i] = 0;
        else begin
          if (tick) m_rem[i]--;
          m_age[i]++;
        end
      end
    end
    if (acc && v < N && note_dur_ms != 0) begin
      m_play[v] = 1;
      m_rem[v]  = int'(note_dur_ms);
      m_hp[v]   = int'(note_half_period);
      m_age[v]  = 0;
    end
    for (int i = 0; i < N; i++) e.active[i] = m_play[i];
    e.snd   = snd;
    e.ready = (v >= N) || !m_play[v];
    sb.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        exp_t       e;
        logic [7:0] el;
        e  = sb.pop_front();
        el = '0;
        for (int i = 0; i < N; i++) el[i] = e.active[i];
        el[7] = e.snd;
        check("voice_active", 32'(voice_active), 32'(e.active));
        check("sound",        32'(sound),        32'(e.snd));
        check("led",          32'(led),          32'(el));
        check("note_ready",   32'(note_ready),   32'(e.ready));
      end
    end
  end

  // Offer a note for up to max_wait cycles; taken reports whether it was accepted.
  task automatic offer(input int v, input int hp, input int dur, input int max_wait, output bit taken);
    @(negedge clk);
    note_voice       = VSEL_W'(v);
    note_half_period = 12'(hp);
    note_dur_ms      = 12'(dur);
    note_valid       = 1'b1;
    taken            = 1'b0;
    for (int k = 0; k < max_wait && !taken; k++) begin
      #1;
      if (note_ready) taken = 1'b1;
      @(negedge clk);
    end
    note_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sound",  32'(sound),        32'd0);
    check("rst_led",    32'(led),          32'd0);
    check("rst_active", 32'(voice_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(note_ready), 32'd1);
  endtask

  initial begin
    bit taken;
    rst_n            = 1'b0;
    ticks_per_milli  = '0;
    note_valid       = 1'b0;
    note_voice       = '0;
    note_half_period = '0;
    note_dur_ms      = '0;
    #1;
    check("init_sound",  32'(sound),        32'd0);
    check("init_led",    32'(led),          32'd0);
    check("init_active", 32'(voice_active), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("init_ready", 32'(note_ready), 32'd1);

    // Basic tone: 2 ms at 10 cycles/ms, half period 3.
    ticks_per_milli = 16'd10;
    offer(0, 3, 2, 4, taken);
    check("v0_taken", 32'(taken), 32'd1);
    idle(40);

    // Busy voice refuses; out-of-range voice is taken and dropped.
    offer(1, 4, 8, 4, taken);
    check("v1_taken", 32'(taken), 32'd1);
    idle(10);
    offer(1, 5, 5, 4, taken);
    check("v1_busy_refused", 32'(taken), 32'd0);
    offer(N, 7, 7, 4, taken);
    check("oor_taken", 32'(taken), 32'd1);
    offer(7, 2, 3, 4, taken);
    check("oor7_taken", 32'(taken), 32'd1);

    // Rest note and zero-duration discard.
    offer(2, 0, 3, 4, taken);
    check("rest_taken", 32'(taken), 32'd1);
    offer(3, 2, 0, 4, taken);
    check("dur0_taken", 32'(taken), 32'd1);
    idle(100);

    // Halted prescaler freezes a note; tpm=1 gives one tick per cycle.
    offer(4, 2, 3, 4, taken);
    ticks_per_milli = 16'd0;
    idle(200);
    check("frozen_active", 32'(voice_active[4]), 32'd1);
    ticks_per_milli = 16'd1;
    offer(0, 1, 5, 4, taken);
    check("tpm1_taken", 32'(taken), 32'd1);
    idle(12);

    // Lower the prescaler below its current count mid-note.
    ticks_per_milli = 16'd50;
    offer(1, 3, 4, 4, taken);
    idle(30);
    ticks_per_milli = 16'd5;
    idle(40);

    // Reset in the middle of a note.
    offer(2, 2, 9, 4, taken);
    idle(5);
    async_reset();

    // Overlapping long notes so several waves are high together.
    ticks_per_milli = 16'd3;
    offer(0, 40, 20, 4, taken);
    offer(1, 40, 20, 4, taken);
    offer(2, 17, 15, 4, taken);
    idle(80);

    // Randomised traffic.
    for (int it = 0; it < 1200; it++) begin
      if ($urandom_range(0, 9) == 0) ticks_per_milli = 16'($urandom_range(0, 6));
      offer($urandom_range(0, (1 << VSEL_W) - 1),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 6),
            $urandom_range(0, 5), $urandom_range(1, 3), taken);
      idle($urandom_range(0, 5));
    end

    ticks_per_milli = 16'd1;
    idle(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
